cnn_mul_rr_mac_arb: RTL and testbench

Round-robin arbiter and accumulate sequencer that time-shares one signed 9-bit × 14-bit multiplier (24-bit product) among several conv2 requesters. Each requester streams operand pairs with a `last` marker. The block issues one pair per cycle to the shared multiplier and keeps a private accumulator per requester. When a `last` beat commits, it returns that requester's finished sum. The block sits between the conv2 loop datapaths and the single multiplier instance, which is instantiated outside this block.

---
 rtl/cnn_mul_rr_mac_arb_if.sv | 28 ++
 rtl/cnn_mul_rr_mac_arb.sv | 69 ++++++
 tb/tb_cnn_mul_rr_mac_arb.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cnn_mul_rr_mac_arb_if.sv
// cnn_mul_rr_mac_arb_if: requester, shared-multiplier and response signals of the MAC arbiter
interface cnn_mul_rr_mac_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int A_W = 9,
  parameter int B_W = 14,
  parameter int P_W = 24,
  parameter int ACC_W = 32
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [NUM_REQ-1:0] req_last;
  logic [A_W-1:0] mul_a;
  logic [B_W-1:0] mul_b;
  logic [P_W-1:0] mul_p;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [ACC_W-1:0] rsp_data;
  logic busy;
  modport master (
    output req_valid, req_a, req_b, req_last, mul_p,
    input req_ready, mul_a, mul_b, rsp_valid, rsp_data, busy
  );
  modport slave (
    input req_valid, req_a, req_b, req_last, mul_p,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/cnn_mul_rr_mac_arb.sv
// cnn_mul_rr_mac_arb: round-robin sharing of one multiplier with a private accumulator per requester
module cnn_mul_rr_mac_arb #(
  parameter int NUM_REQ = 4,
  parameter int A_W = 9,
  parameter int B_W = 14,
  parameter int P_W = 24,
  parameter int ACC_W = 32
) (
  input logic ap_clk,
  input logic ap_rst_n,
  cnn_mul_rr_mac_arb_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] ptr, gid, s1_id;
  logic found, s1_vld, s1_last;
  logic [A_W-1:0] s1_a;
  logic [B_W-1:0] s1_b;
  logic [ACC_W-1:0] acc [NUM_REQ];
  logic [ACC_W-1:0] sum;
  int idx;
  always_comb begin
    gid = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx[IW-1:0]]) begin
        found = 1'b1;
        gid = idx[IW-1:0];
      end
    end
  end
  assign bus.req_ready = found ? NUM_REQ'(1) << gid : '0;
  assign bus.mul_a = s1_a;
  assign bus.mul_b = s1_b;
  assign bus.busy = s1_vld | |bus.rsp_valid;
  // commit reads acc in the same cycle it is written, so back-to-back beats of one id never see stale data
  assign sum = acc[s1_id] + {{(ACC_W-P_W){bus.mul_p[P_W-1]}}, bus.mul_p};
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr <= '0;
      s1_vld <= 1'b0;
      s1_last <= 1'b0;
      s1_id <= '0;
      s1_a <= '0;
      s1_b <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data <= '0;
      for (int i = 0; i < NUM_REQ; i++) acc[i] <= '0;
    end else begin
      s1_vld <= found;
      if (found) begin
        ptr <= (gid == IW'(NUM_REQ-1)) ? '0 : gid + 1'b1;
        s1_id <= gid;
        s1_last <= bus.req_last[gid];
        s1_a <= bus.req_a[gid*A_W +: A_W];
        s1_b <= bus.req_b[gid*B_W +: B_W];
      end
      bus.rsp_valid <= '0;
      if (s1_vld) begin
        acc[s1_id] <= s1_last ? '0 : sum;
        if (s1_last) begin
          bus.rsp_valid[s1_id] <= 1'b1;
          bus.rsp_data <= sum;
        end
      end
    end
  end
endmodule

// File: tb/tb_cnn_mul_rr_mac_arb.sv
// tb_cnn_mul_rr_mac_arb: directed and random streams checked against a sum-per-requester reference model
module tb_cnn_mul_rr_mac_arb;
  localparam int N = 4, AW = 9, BW = 14, PW = 24, CW = 32;
  typedef struct {logic [AW-1:0] a; logic [BW-1:0] b; logic last;} beat_t;
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;
  cnn_mul_rr_mac_arb_if #(.NUM_REQ(N), .A_W(AW), .B_W(BW), .P_W(PW), .ACC_W(CW)) bus();
  cnn_mul_rr_mac_arb #(.NUM_REQ(N), .A_W(AW), .B_W(BW), .P_W(PW), .ACC_W(CW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus)
  );
  logic signed [PW-1:0] pm;
  assign pm = $signed(bus.mul_a) * $signed(bus.mul_b);
  assign bus.mul_p = pm;
  beat_t q[N][$];
  logic [N-1:0] mask;
  int vectors = 0, miscompares = 0, n = 0, lastg;
  logic [31:0] macc[N];
  logic [AW-1:0] m_a;
  logic [BW-1:0] m_b;
  logic [31:0] m_rd, obs_rd;
  logic [N-1:0] rv_at[4];
  logic [31:0] rd_at[4];
  logic busy_at[4];
  int gcnt[N], glast[N], gmax;
  int glog[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < N; i++) macc[i] = 0;
    for (int i = 0; i < 4; i++) begin rv_at[i] = '0; rd_at[i] = 0; busy_at[i] = 1'b0; end
    m_a = '0; m_b = '0; m_rd = 0; lastg = N - 1;
  endtask

  task automatic clr_stats();
    glog.delete();
    gmax = 0;
    for (int i = 0; i < N; i++) begin gcnt[i] = 0; glast[i] = -1; end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += q[i].size();
    return s;
  endfunction

  task automatic cycle();
    int g;
    logic [N-1:0] er;
    beat_t bt;
    int p;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = mask[i] && q[i].size() > 0;
      bus.req_a[i*AW +: AW] = q[i].size() > 0 ? q[i][0].a : '0;
      bus.req_b[i*BW +: BW] = q[i].size() > 0 ? q[i][0].b : '0;
      bus.req_last[i] = q[i].size() > 0 ? q[i][0].last : 1'b0;
    end
    #1;
    // grant goes to the first valid requester after the one granted last
    g = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (lastg + 1 + k) % N;
      if (g < 0 && bus.req_valid[i]) g = i;
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    if (rv_at[n%4] != 0) m_rd = rd_at[n%4];
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("mul_a", 32'(bus.mul_a), 32'(m_a));
    chk("mul_b", 32'(bus.mul_b), 32'(m_b));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(rv_at[n%4]));
    chk("rsp_data", bus.rsp_data, m_rd);
    chk("busy", 32'(bus.busy), 32'(busy_at[n%4]));
    if (bus.rsp_valid != 0) obs_rd = bus.rsp_data;
    for (int i = 0; i < N; i++) if (bus.req_ready[i] === 1'b1) begin
      glog.push_back(i);
      if (glast[i] >= 0 && n - glast[i] - 1 > gmax) gmax = n - glast[i] - 1;
      glast[i] = n;
      gcnt[i]++;
    end
    rv_at[n%4] = '0;
    busy_at[n%4] = 1'b0;
    if (ap_rst_n && g >= 0) begin
      bt = q[g].pop_front();
      p = int'($signed(bt.a)) * int'($signed(bt.b));
      macc[g] = macc[g] + 32'(p);
      m_a = bt.a;
      m_b = bt.b;
      lastg = g;
      busy_at[(n+1)%4] = 1'b1;
      if (bt.last) begin
        rv_at[(n+2)%4][g] = 1'b1;
        rd_at[(n+2)%4] = macc[g];
        busy_at[(n+2)%4] = 1'b1;
        macc[g] = 0;
      end
    end
    @(posedge ap_clk);
    n++;
    @(negedge ap_clk);
  endtask

  task automatic drain(bit rnd);
    int c = 0;
    while (pending() > 0 && c < 4000) begin
      mask = rnd ? N'($urandom) : '1;
      cycle();
      c++;
    end
    chk("drain_done", pending(), 0);
    mask = '1;
    repeat (3) cycle();
  endtask

  task automatic push(int r, int a, int b, bit last);
    beat_t bt;
    bt.a = AW'(a);
    bt.b = BW'(b);
    bt.last = last;
    q[r].push_back(bt);
  endtask

  initial begin
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_last = '0;
    mask = '1;
    mreset();
    clr_stats();
    @(posedge ap_clk);
    @(negedge ap_clk);
    push(0, 1, 1, 0); push(0, 1, 1, 1);
    push(1, 1, 2, 1); push(2, 2, 2, 1); push(3, 3, 2, 1);
    repeat (2) cycle();
    ap_rst_n = 1'b1;
    clr_stats();
    drain(0);
    chk("order_len", glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("order", glog[i], i % 4);

    push(2, 3, 4, 0); push(2, -5, 7, 0); push(2, -256, 8191, 1);
    drain(0);
    chk("sum3", obs_rd, -32'sd2096919);

    clr_stats();
    for (int j = 0; j < 2; j++) begin push(0, 1, 1, j == 1); push(1, 1, 1, j == 1); end
    drain(0);
    chk("ilv_len", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("ilv_order", glog[i], i % 2);
    chk("ilv_sum", obs_rd, 2);

    for (int j = 0; j < 4; j++) push(3, 2, 3, j == 3);
    drain(0);
    chk("b2b_sum", obs_rd, 24);
    push(3, 1, 1, 1);
    drain(0);
    chk("b2b_cleared", obs_rd, 1);

    for (int j = 0; j < 260; j++) push(1, -256, -8192, j == 259);
    drain(0);
    chk("wrap_sum", obs_rd, 545259520);

    clr_stats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 10; j++) push(i, int'($urandom), int'($urandom), j == 9);
    repeat (40) cycle();
    for (int i = 0; i < N; i++) chk("fair_cnt", gcnt[i], 10);
    chk("fair_gap_ok", 32'(gmax <= 3), 1);
    drain(0);

    for (int j = 0; j < 300; j++) push(int'($urandom_range(N-1)), int'($urandom), int'($urandom), $urandom_range(3) == 0);
    for (int i = 0; i < N; i++) push(i, int'($urandom), int'($urandom), 1);
    drain(1);

    push(0, 5, 5, 0); push(0, 5, 5, 0); push(0, 5, 5, 1);
    repeat (2) cycle();
    ap_rst_n = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    mreset();
    repeat (2) cycle();
    ap_rst_n = 1'b1;
    repeat (2) cycle();
    push(0, 1, 1, 1);
    drain(0);
    chk("post_reset_sum", obs_rd, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
